cpu_run_ctrl: RTL and testbench

- Execution sequencer for the single-cycle RISC-V datapath: PC, register file, data memory and parallel output.
- Replaces the free-running divided clock. The whole datapath runs on the 50 MHz clock and advances only in cycles where cpu_en is high.
- Provides RUN (paced), single-STEP (debounced key), PC breakpoint and halt-instruction detection, with the state shown on LEDs/LCD.

---
 rtl/cpu_ctrl_pkg.sv | 20 ++
 rtl/cpu_run_ctrl_if.sv | 37 +++
 rtl/key_debounce.sv | 61 ++++++
 rtl/cpu_run_ctrl.sv | 122 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the execution sequencer.
//   cpu_state_e : sequencer state encoding, also driven on the state output
//   HALT_INST   : instruction that stops RUN mode (beq x0,x0,0)
//   is_halt_inst: helper comparing an instruction word against HALT_INST
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_STEP = 2'b10,
      ST_HALT = 2'b11
   } cpu_state_e;

   localparam logic [31:0] HALT_INST = 32'h0000_0063;

   function automatic logic is_halt_inst(input logic [31:0] inst);
      return inst == HALT_INST;
   endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: board/datapath-side signals of the execution sequencer.
//   key_step : raw step pushbutton, active-low, asynchronous
//   sw_run   : 1 = run, 0 = stop
//   bp_en    : breakpoint enable
//   bp_addr  : breakpoint PC
//   pc, inst : current PC and instruction from the datapath
//   cpu_en   : one-cycle execute strobe to the datapath
//   state    : sequencer state (00 IDLE, 01 RUN, 10 STEP, 11 HALT)
//   halted   : high while in HALT
//   step_cnt : executed instruction count, saturating
//   tick_led : toggles on every executed RUN tick
// Modport master is the sequencer, slave is the datapath/board side.
interface cpu_run_ctrl_if #(
   parameter int unsigned PC_W = 8
);
   logic            key_step;
   logic            sw_run;
   logic            bp_en;
   logic [PC_W-1:0] bp_addr;
   logic [PC_W-1:0] pc;
   logic [31:0]     inst;
   logic            cpu_en;
   logic [1:0]      state;
   logic            halted;
   logic [15:0]     step_cnt;
   logic            tick_led;

   modport master (
      input  key_step, sw_run, bp_en, bp_addr, pc, inst,
      output cpu_en, state, halted, step_cnt, tick_led
   );

   modport slave (
      output key_step, sw_run, bp_en, bp_addr, pc, inst,
      input  cpu_en, state, halted, step_cnt, tick_led
   );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: synchronises and debounces an active-low pushbutton.
//   clk   : system clock
//   rst   : asynchronous reset, active-low
//   key_n : raw key, active-low, asynchronous to clk
//   level : accepted (debounced) key level, 1 = released
//   press : one-cycle pulse on the accepted 1->0 transition
module key_debounce #(
   parameter int unsigned DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             key_s;

   assign key_s = sync_q[1];

   // The counter only runs while the synchronised key disagrees with the
   // accepted level; any agreeing sample restarts the stability window.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      press_d = 1'b0;
      if (key_s != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = key_s;
            press_d = level_q;  // only the 1->0 change is a press
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_n};
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: execution sequencer for the single-cycle RISC-V datapath.
// The datapath runs on clk and advances only in cycles where cpu_en is high.
//   clk : system clock
//   rst : asynchronous reset, active-low
//   bus : cpu_run_ctrl_if master (key/switch/breakpoint inputs, pc/inst,
//         cpu_en strobe, state/halted/step_cnt/tick_led status)
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int unsigned RUN_HZ     = 2,
   parameter int unsigned DEB_CYCLES = 1000000,
   parameter int unsigned PC_W       = 8
) (
   input  logic          clk,
   input  logic          rst,
   cpu_run_ctrl_if.master bus
);

   localparam int unsigned TICK_DIV = CLK_HZ / RUN_HZ;
   localparam int unsigned PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   cpu_state_e       state_q, state_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic             cpu_en_q, cpu_en_d;
   logic             led_q, led_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             press;
   logic             run_tick;
   logic             bp_hit;
   logic [PC_W-1:0]  pc_s, bp_addr_s;
   // Accepted key level is not needed here; press carries the event.
   logic             unused_key_level;

   key_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_key_debounce (
      .clk   (clk),
      .rst   (rst),
      .key_n (bus.key_step),
      .level (unused_key_level),
      .press (press)
   );

   assign pc_s      = bus.pc;
   assign bp_addr_s = bus.bp_addr;
   assign run_tick  = (state_q == ST_RUN) && (presc_q == PRE_LAST);
   assign bp_hit    = bus.bp_en && (pc_s == bp_addr_s);

   always_comb begin
      state_d  = state_q;
      presc_d  = '0;
      cpu_en_d = 1'b0;
      led_d    = led_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.sw_run) begin
               state_d = ST_RUN;
            end else if (press) begin
               state_d = ST_STEP;
            end
         end
         ST_RUN: begin
            // Leaving RUN beats a same-cycle tick; the prescaler drops to 0.
            if (!bus.sw_run) begin
               state_d = ST_IDLE;
            end else if (run_tick) begin
               if (bp_hit || is_halt_inst(bus.inst)) begin
                  state_d = ST_HALT;
               end else begin
                  cpu_en_d = 1'b1;
                  led_d    = ~led_q;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         ST_STEP: begin
            // Stepping deliberately skips breakpoint and halt checks.
            cpu_en_d = 1'b1;
            state_d  = ST_IDLE;
         end
         ST_HALT: begin
            if (press) begin
               state_d = ST_STEP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cpu_en_q && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         presc_q  <= '0;
         cpu_en_q <= 1'b0;
         led_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         cpu_en_q <= cpu_en_d;
         led_q    <= led_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.cpu_en   = cpu_en_q;
   assign bus.state    = state_q;
   assign bus.halted   = (state_q == ST_HALT);
   assign bus.step_cnt = cnt_q;
   assign bus.tick_led = led_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl with CLK_HZ=8, RUN_HZ=1 (tick every 8 cycles)
// and DEB_CYCLES=4. A vector table covers run/reset/breakpoint; hand-written
// sequences cover stepping, halt instruction and debounce.
module tb_cpu_run_ctrl;
   import cpu_ctrl_pkg::*;

   localparam int unsigned PC_W = 8;
   localparam logic [31:0] ADDI = 32'h0050_0093;

   logic clk = 1'b0;
   logic rst;

   cpu_run_ctrl_if #(.PC_W(PC_W)) bus ();

   cpu_run_ctrl #(
      .CLK_HZ     (8),
      .RUN_HZ     (1),
      .DEB_CYCLES (4),
      .PC_W       (PC_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] st, input int max, output int c, output int en);
      c  = 0;
      en = 0;
      while (bus.state !== st && c < max) begin
         cyc(1);
         c++;
         if (bus.cpu_en === 1'b1) en++;
      end
   endtask

   task automatic wait_en(input int max, output int c);
      c = 0;
      while (bus.cpu_en !== 1'b1 && c < max) begin
         cyc(1);
         c++;
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic en,
                            input logic halt, input logic [15:0] cnt, input logic led);
      check({tag, " state"}, bus.state, st);
      check({tag, " cpu_en"}, bus.cpu_en, en);
      check({tag, " halted"}, bus.halted, halt);
      check({tag, " step_cnt"}, bus.step_cnt, cnt);
      check({tag, " tick_led"}, bus.tick_led, led);
   endtask

   typedef struct {
      logic        rst;
      logic        sw_run;
      logic        bp_en;
      logic [7:0]  pc;
      int          n;      // edges to advance; 0 = settle only
      logic [1:0]  st;
      logic        en;
      logic        halt;
      logic [15:0] cnt;
      logic        led;
   } vec_t;

   localparam int NVEC = 22;
   vec_t tbl [NVEC];

   initial begin
      int c, en, steps, en_at, step_at;

      // rst sw  bpen pc     n  state    en    halt  cnt    led
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1, ST_RUN,  1'b0, 1'b0, 16'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 7, ST_RUN,  1'b0, 1'b0, 16'd0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1, ST_RUN,  1'b1, 1'b0, 16'd0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1, ST_RUN,  1'b0, 1'b0, 16'd1, 1'b1};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 6, ST_RUN,  1'b0, 1'b0, 16'd1, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1, ST_RUN,  1'b1, 1'b0, 16'd1, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1, ST_RUN,  1'b0, 1'b0, 16'd2, 1'b0};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 6, ST_RUN,  1'b0, 1'b0, 16'd2, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1, ST_RUN,  1'b1, 1'b0, 16'd2, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1, ST_RUN,  1'b0, 1'b0, 16'd3, 1'b1};
      // async reset mid-RUN, then released with sw_run=0
      tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, ST_IDLE, 1'b0, 1'b0, 16'd0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 3, ST_IDLE, 1'b0, 1'b0, 16'd0, 1'b0};
      // sw_run drops in the tick decision cycle: no pulse
      tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1, ST_RUN,  1'b0, 1'b0, 16'd0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 7, ST_RUN,  1'b0, 1'b0, 16'd0, 1'b0};
      tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h00, 1, ST_IDLE, 1'b0, 1'b0, 16'd0, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h00, 1, ST_IDLE, 1'b0, 1'b0, 16'd0, 1'b0};
      // pc == bp_addr with bp_en=0 executes; with bp_en=1 halts
      tbl[16] = '{1'b1, 1'b1, 1'b0, 8'h08, 8, ST_RUN,  1'b0, 1'b0, 16'd0, 1'b0};
      tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h08, 1, ST_RUN,  1'b1, 1'b0, 16'd0, 1'b1};
      tbl[18] = '{1'b1, 1'b1, 1'b0, 8'h08, 1, ST_RUN,  1'b0, 1'b0, 16'd1, 1'b1};
      tbl[19] = '{1'b1, 1'b1, 1'b1, 8'h08, 6, ST_RUN,  1'b0, 1'b0, 16'd1, 1'b1};
      tbl[20] = '{1'b1, 1'b1, 1'b1, 8'h08, 1, ST_HALT, 1'b0, 1'b1, 16'd1, 1'b1};
      tbl[21] = '{1'b1, 1'b1, 1'b1, 8'h08, 5, ST_HALT, 1'b0, 1'b1, 16'd1, 1'b1};

      rst          = 1'b0;
      bus.key_step = 1'b1;
      bus.sw_run   = 1'b0;
      bus.bp_en    = 1'b0;
      bus.bp_addr  = 8'h08;
      bus.pc       = 8'h00;
      bus.inst     = ADDI;
      cyc(3);
      check_all("reset", ST_IDLE, 1'b0, 1'b0, 16'd0, 1'b0);
      rst = 1'b1;
      cyc(2);
      check_all("post-reset", ST_IDLE, 1'b0, 1'b0, 16'd0, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         rst        = tbl[i].rst;
         bus.sw_run = tbl[i].sw_run;
         bus.bp_en  = tbl[i].bp_en;
         bus.pc     = tbl[i].pc;
         if (tbl[i].n == 0) #1;
         else cyc(tbl[i].n);
         check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].en, tbl[i].halt, tbl[i].cnt,
                   tbl[i].led);
      end

      // Step past the breakpoint: HALT, pc == bp_addr, sw_run=1.
      bus.key_step = 1'b0;
      wait_state(ST_STEP, 20, c, en);
      check("bpstep reach STEP", bus.state, ST_STEP);
      check("bpstep press latency", c, 7);
      check("bpstep early cpu_en", en, 0);
      check("bpstep halted", bus.halted, 1'b0);
      bus.key_step = 1'b1;
      cyc(1);
      check("bpstep idle", bus.state, ST_IDLE);
      check("bpstep cpu_en", bus.cpu_en, 1'b1);
      bus.pc = 8'h0C;
      cyc(1);
      check("bpstep rerun", bus.state, ST_RUN);
      check("bpstep cpu_en off", bus.cpu_en, 1'b0);
      check("bpstep step_cnt", bus.step_cnt, 16'd2);
      wait_en(12, c);
      check("resume tick latency", c, 8);
      check("resume state", bus.state, ST_RUN);
      cyc(1);
      check("resume step_cnt", bus.step_cnt, 16'd3);

      // Halt instruction, then step over it.
      bus.inst = HALT_INST;
      wait_state(ST_HALT, 12, c, en);
      check("hinst reach HALT", bus.state, ST_HALT);
      check("hinst latency", c, 7);
      check("hinst no cpu_en", en, 0);
      check("hinst halted", bus.halted, 1'b1);
      check("hinst step_cnt", bus.step_cnt, 16'd3);
      bus.sw_run   = 1'b0;
      bus.key_step = 1'b0;
      wait_state(ST_STEP, 20, c, en);
      check("hinst step state", bus.state, ST_STEP);
      check("hinst step no early en", en, 0);
      cyc(1);
      check("hinst step cpu_en", bus.cpu_en, 1'b1);
      check("hinst step idle", bus.state, ST_IDLE);
      cyc(1);
      check("hinst step_cnt after", bus.step_cnt, 16'd4);
      bus.key_step = 1'b1;
      cyc(10);

      // Bounce shorter than the debounce window is ignored.
      bus.key_step = 1'b0;
      cyc(2);
      bus.key_step = 1'b1;
      en    = 0;
      steps = 0;
      for (int k = 0; k < 12; k++) begin
         cyc(1);
         if (bus.cpu_en === 1'b1) en++;
         if (bus.state !== ST_IDLE) steps++;
      end
      check("bounce cpu_en count", en, 0);
      check("bounce non-idle cycles", steps, 0);

      // Long hold: exactly one STEP and one pulse, STEP then IDLE.
      bus.key_step = 1'b0;
      en      = 0;
      steps   = 0;
      en_at   = -1;
      step_at = -1;
      for (int k = 0; k < 30; k++) begin
         cyc(1);
         if (bus.state === ST_STEP) begin
            steps++;
            step_at = k;
         end
         if (bus.cpu_en === 1'b1) begin
            en++;
            en_at = k;
            check("hold pulse in IDLE", bus.state, ST_IDLE);
         end
      end
      check("hold cpu_en count", en, 1);
      check("hold STEP cycles", steps, 1);
      check("hold pulse follows STEP", en_at, step_at + 1);
      check("hold step_cnt", bus.step_cnt, 16'd5);
      bus.key_step = 1'b1;
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
